// File: rtl/gex_leak_sequencer.sv
// gex_leak_sequencer
//   Walks neuron indices FirstNeuron..LastNeuron once per Start. For each
//   index it reads gex from neuron state memory, hands it to the shared
//   combinational gex leak unit, and writes the leaked value back to the
//   same address. Three-stage pipeline, one neuron per cycle. Pause yields
//   the read port without disturbing entries already in flight.
//
// Ports
//   Clock, Reset        rising-edge clock, synchronous active-high reset
//   Start, Pause        sweep request (IDLE only) / read suppression
//   FirstNeuron,
//   LastNeuron          inclusive index range, latched at Start
//   DeltaT, Taugex      leak parameters, latched at Start
//   RdEn/RdAddr/RdData  memory read port (data valid one cycle after RdEn)
//   LeakGex/LeakDeltaT/
//   LeakTaugex          operands to the leak unit
//   LeakGexOut          leak unit result (combinational)
//   WrEn/WrAddr/WrData  memory write port
//   Busy, Done          sweep in progress / one-cycle end-of-sweep pulse
module gex_leak_sequencer #(
    parameter int INTEGER_WIDTH     = 32,
    parameter int DATA_WIDTH_FRAC   = 32,
    parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int DELTAT_WIDTH      = 4,
    parameter int NEURON_ADDR_WIDTH = 11
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         Start,
    input  logic                         Pause,
    input  logic [NEURON_ADDR_WIDTH-1:0] FirstNeuron,
    input  logic [NEURON_ADDR_WIDTH-1:0] LastNeuron,
    input  logic [DELTAT_WIDTH-1:0]      DeltaT,
    input  logic [INTEGER_WIDTH-1:0]     Taugex,
    output logic                         RdEn,
    output logic [NEURON_ADDR_WIDTH-1:0] RdAddr,
    input  logic [DATA_WIDTH-1:0]        RdData,
    output logic [DATA_WIDTH-1:0]        LeakGex,
    output logic [DELTAT_WIDTH-1:0]      LeakDeltaT,
    output logic [INTEGER_WIDTH-1:0]     LeakTaugex,
    input  logic [DATA_WIDTH-1:0]        LeakGexOut,
    output logic                         WrEn,
    output logic [NEURON_ADDR_WIDTH-1:0] WrAddr,
    output logic [DATA_WIDTH-1:0]        WrData,
    output logic                         Busy,
    output logic                         Done
);

    localparam logic [NEURON_ADDR_WIDTH-1:0] ADDR_ONE = NEURON_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t                         state, state_nxt;
    logic [NEURON_ADDR_WIDTH-1:0]   ptr, ptr_nxt;
    logic [NEURON_ADDR_WIDTH-1:0]   last_q;
    logic                           load;

    // rd_*: a read was issued last cycle, RdData is valid now.
    // lk_*: LeakGex holds a valid operand, result is written next edge.
    logic                           rd_vld_q;
    logic [NEURON_ADDR_WIDTH-1:0]   rd_addr_q;
    logic                           lk_vld_q;
    logic [NEURON_ADDR_WIDTH-1:0]   lk_addr_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        load      = 1'b0;
        RdEn      = 1'b0;
        Busy      = (state != ST_IDLE);
        Done      = (state == ST_DONE);
        case (state)
            ST_IDLE: begin
                if (Start) begin
                    load      = 1'b1;
                    ptr_nxt   = FirstNeuron;
                    state_nxt = (FirstNeuron <= LastNeuron) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (!Pause) begin
                    RdEn = 1'b1;
                    // Terminate on equality and hold the pointer on the last
                    // index so a sweep ending at the top address never wraps.
                    if (ptr == last_q) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        ptr_nxt = ptr + ADDR_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                // Once nothing is waiting to enter stages 2 or 3, the final
                // write is on the port this cycle and Done can follow.
                if (!rd_vld_q && !lk_vld_q) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign RdAddr = ptr;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr        <= '0;
            last_q     <= '0;
            LeakDeltaT <= '0;
            LeakTaugex <= '0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            lk_vld_q   <= 1'b0;
            lk_addr_q  <= '0;
            LeakGex    <= '0;
            WrEn       <= 1'b0;
            WrAddr     <= '0;
            WrData     <= '0;
        end else begin
            ptr <= ptr_nxt;
            if (load) begin
                last_q     <= LastNeuron;
                LeakDeltaT <= DeltaT;
                LeakTaugex <= Taugex;
            end

            rd_vld_q <= RdEn;
            if (RdEn) begin
                rd_addr_q <= ptr;
            end

            lk_vld_q <= rd_vld_q;
            if (rd_vld_q) begin
                LeakGex   <= RdData;
                lk_addr_q <= rd_addr_q;
            end

            WrEn <= lk_vld_q;
            if (lk_vld_q) begin
                WrData <= LeakGexOut;
                WrAddr <= lk_addr_q;
            end
        end
    end

endmodule
